// File: rtl/uart_receiver_if.sv
// Serial line in, received byte and status pulses out, for the 8N1 UART receiver.
interface uart_receiver_if;
    logic       rx_in;
    logic [7:0] d_out;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (output rx_in, input d_out, input rx_valid, input frame_err, input rx_busy);
    modport slave  (input rx_in, output d_out, output rx_valid, output frame_err, output rx_busy);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error flag.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          reset,
    uart_receiver_if.slave bus
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

    state_e        state_q, state_d;
    logic          sync_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          busy_q;

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            dout_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= bus.rx_in;
            rx_s_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= (state_q != IDLE);
        end
    end

    // Next-state, bit timing and byte assembly
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == HALF_END) begin
                    if (!rx_s_q) begin
                        state_d = DATA;
                        cnt_d   = {CW{1'b0}};
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = {CW{1'b0}};
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a following start edge is not missed
                if (cnt_q == BIT_END) begin
                    cnt_d = {CW{1'b0}};
                    if (rx_s_q) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.d_out     = dout_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = err_q;
    assign bus.rx_busy   = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level scoreboard plus directed scenarios.
module tb_uart_receiver;
    localparam int C = 16;

    typedef struct packed {
        logic       ok;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_seen = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   n_err = 0;
    logic [7:0] m_dout = 8'h00;
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;
    exp_t q[$];
    int   valid_cyc[$];
    logic [7:0] got[$];

    uart_receiver_if bus();

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_seen <= reset;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest frame still expected
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_seen) begin
            chk("rst_dout", bus.d_out, 0);
            chk("rst_valid", bus.rx_valid, 0);
            chk("rst_err", bus.frame_err, 0);
            chk("rst_busy", bus.rx_busy, 0);
            m_dout = 8'h00;
            prev_valid = 1'b0;
            prev_err = 1'b0;
        end else begin
            chk("exclusive", bus.rx_valid & bus.frame_err, 0);
            if (prev_valid) begin
                chk("valid_width", bus.rx_valid, 0);
                chk("busy_drop", bus.rx_busy, 0);
            end
            if (prev_err) chk("err_width", bus.frame_err, 0);
            if (bus.rx_valid) begin
                n_valid++;
                valid_cyc.push_back(cyc);
                got.push_back(bus.d_out);
                chk("valid_busy", bus.rx_busy, 1);
                if (q.size() == 0) begin
                    chk("unexpected_valid", bus.rx_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("valid_kind", e.ok, 1);
                    chk("valid_byte", bus.d_out, e.b);
                    m_dout = e.b;
                end
            end
            if (bus.frame_err) begin
                n_err++;
                if (q.size() == 0) begin
                    chk("unexpected_err", bus.frame_err, 0);
                end else begin
                    e = q.pop_front();
                    chk("err_kind", e.ok, 0);
                end
            end
            chk("dout_hold", bus.d_out, m_dout);
            prev_valid = bus.rx_valid;
            prev_err = bus.frame_err;
        end
    end

    task automatic drive(input logic v, input int n);
        bus.rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input bit push);
        exp_t e;
        if (push) begin
            e.ok = stop_ok;
            e.b = b;
            q.push_back(e);
        end
        drive(1'b0, C);
        for (int k = 0; k < 8; k++) drive(b[k], C);
        drive(stop_ok, C);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int v0;
        int e0;
        int vc;
        int busy_n;
        int seg;
        logic lv[10];
        int bnd[10];
        logic [7:0] jb;
        exp_t e;

        bus.rx_in = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_busy", bus.rx_busy, 0);
        chk("reset_dout", bus.d_out, 8'h00);

        // 1: single frame
        v0 = n_valid;
        send_frame(8'hAA, 1'b1, 1'b1);
        drive(1'b1, 20);
        wait_drain();
        chk("t1_count", n_valid - v0, 1);
        chk("t1_dout", bus.d_out, 8'hAA);
        chk("t1_no_err", n_err, 0);

        // 2: back-to-back frames, single stop bit
        v0 = n_valid;
        vc = valid_cyc.size();
        send_frame(8'hCC, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        drive(1'b1, 20);
        wait_drain();
        chk("t2_count", n_valid - v0, 2);
        if (valid_cyc.size() >= vc + 2) begin
            chk("t2_spacing", valid_cyc[vc+1] - valid_cyc[vc], 10 * C);
            chk("t2_first", got[vc], 8'hCC);
        end else begin
            chk("t2_pulses_seen", valid_cyc.size() - vc, 2);
        end
        chk("t2_dout", bus.d_out, 8'hF0);

        // 3: 4-cycle start glitch
        v0 = n_valid;
        e0 = n_err;
        busy_n = 0;
        bus.rx_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) bus.rx_in = 1'b1;
            @(negedge clk);
            busy_n += int'(bus.rx_busy);
        end
        chk("t3_busy_cycles", busy_n, 8);
        chk("t3_no_valid", n_valid - v0, 0);
        chk("t3_no_err", n_err - e0, 0);
        send_frame(8'h55, 1'b1, 1'b1);
        drive(1'b1, 20);
        wait_drain();
        chk("t3_dout", bus.d_out, 8'h55);

        // 4: stop bit low, then break held low
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h3C, 1'b0, 1'b1);
        drive(1'b0, 40);
        drive(1'b1, 20);
        wait_drain();
        chk("t4_err_count", n_err - e0, 1);
        chk("t4_no_valid", n_valid - v0, 0);
        chk("t4_dout_kept", bus.d_out, 8'h55);
        send_frame(8'h81, 1'b1, 1'b1);
        drive(1'b1, 20);
        wait_drain();
        chk("t4_dout_after", bus.d_out, 8'h81);

        // 5: reset during data bit 4
        drive(1'b0, C);
        for (int k = 0; k < 4; k++) drive(1'b1, C);
        drive(1'b0, C / 2);
        reset = 1'b1;
        bus.rx_in = 1'b1;
        @(negedge clk);
        chk("t5_busy", bus.rx_busy, 0);
        chk("t5_dout", bus.d_out, 8'h00);
        chk("t5_valid", bus.rx_valid, 0);
        reset = 1'b0;
        drive(1'b1, 10);
        send_frame(8'h7E, 1'b1, 1'b1);
        drive(1'b1, 20);
        wait_drain();
        chk("t5_dout_after", bus.d_out, 8'h7E);

        // 6: bit edges displaced by +/-6 clocks
        jb = 8'hA5;
        lv[0] = 1'b0;
        for (int k = 0; k < 8; k++) lv[k+1] = jb[k];
        lv[9] = 1'b1;
        for (int j = 1; j < 10; j++) bnd[j] = 16 * j + (((j % 2) == 1) ? 6 : -6);
        e.ok = 1'b1;
        e.b = jb;
        q.push_back(e);
        for (int t = 0; t < 10 * C; t++) begin
            seg = 0;
            for (int j = 1; j < 10; j++) if (t >= bnd[j]) seg = j;
            bus.rx_in = lv[seg];
            @(negedge clk);
        end
        drive(1'b1, 20);
        wait_drain();
        chk("t6_dout", bus.d_out, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
